// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: command codes, frame sizes
// and the sequencer state encoding.
package lcd_pkg;

   localparam logic [2:0] CMD_REFLASH  = 3'd0;
   localparam logic [2:0] CMD_LOAD     = 3'd1;
   localparam logic [2:0] CMD_ZOOM_IN  = 3'd2;
   localparam logic [2:0] CMD_ZOOM_FIT = 3'd3;
   localparam logic [2:0] CMD_RIGHT    = 3'd4;
   localparam logic [2:0] CMD_LEFT     = 3'd5;
   localparam logic [2:0] CMD_UP       = 3'd6;
   localparam logic [2:0] CMD_DOWN     = 3'd7;

   localparam int LOAD_BYTES    = 64;
   localparam int PIX_PER_FRAME = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      LOAD      = 2'd2,
      WAIT_DONE = 2'd3
   } seq_state_e;

   // 5-bit counter step that sticks at 31 so a runaway burst cannot wrap back to 16.
   function automatic logic [4:0] sat_inc5(input logic [4:0] v, input logic en);
      if (en && (v != 5'd31)) begin
         return v + 5'd1;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous command FIFO; head is visible combinationally, a push is
// only seen by the reader on the following cycle.
module lcd_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == FULL_CNT);
   assign empty     = (count_r == '0);
   assign count     = count_r;
   assign head      = mem_r[rd_ptr_r];
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;

   // storage array
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: queues host commands, issues them over cmd/cmd_valid/busy,
// streams the image RAM during LOAD and checks each command's 16-pixel burst.
module lcd_cmd_seq
   import lcd_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] host_cmd,
   input  logic       host_valid,
   output logic       host_ready,
   output logic [2:0] cmd,
   output logic       cmd_valid,
   input  logic       busy,
   input  logic       output_valid,
   output logic       img_rd,
   output logic [5:0] img_addr,
   input  logic [7:0] img_data,
   output logic       cmd_done,
   output logic       seq_busy,
   output logic [1:0] err,
   input  logic       err_clr
);
   localparam int TW = $clog2(TIMEOUT + 1);

   seq_state_e              state_r, state_n;
   logic [2:0]              cmd_r, cmd_n;
   logic                    cmd_valid_r, cmd_valid_n;
   logic                    img_rd_r, img_rd_n;
   logic [5:0]              img_addr_r, img_addr_n;
   logic                    cmd_done_r, cmd_done_n;
   logic [1:0]              err_r, err_set_s;
   logic [4:0]              pix_cnt_r, pix_n, pix_inc_s;
   logic [TW-1:0]           to_cnt_r, to_n;
   logic                    pop_s;
   logic [2:0]              fifo_head_s;
   logic                    fifo_full_s;
   logic                    fifo_empty_s;
   logic [$clog2(DEPTH):0]  fifo_count_s;
   logic                    img_data_unused_s;

   // img_data goes straight to the controller's datain; nothing here consumes it.
   assign img_data_unused_s = ^img_data;

   lcd_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(3)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (host_valid),
      .push_data (host_cmd),
      .pop       (pop_s),
      .head      (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   assign host_ready = !fifo_full_s;
   assign seq_busy   = (state_r != IDLE) || (fifo_count_s != '0);
   assign cmd        = cmd_r;
   assign cmd_valid  = cmd_valid_r;
   assign img_rd     = img_rd_r;
   assign img_addr   = img_addr_r;
   assign cmd_done   = cmd_done_r;
   assign err        = err_r;

   // Outputs are computed one cycle ahead so that they are valid in the state they belong to.
   always_comb begin
      state_n     = state_r;
      cmd_n       = cmd_r;
      cmd_valid_n = 1'b0;
      img_rd_n    = 1'b0;
      img_addr_n  = img_addr_r;
      cmd_done_n  = 1'b0;
      pix_n       = pix_cnt_r;
      pix_inc_s   = pix_cnt_r;
      to_n        = to_cnt_r;
      err_set_s   = 2'b00;
      pop_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s && !busy) begin
               pop_s       = 1'b1;
               cmd_n       = fifo_head_s;
               cmd_valid_n = 1'b1;
               state_n     = ISSUE;
               if (fifo_head_s == CMD_LOAD) begin
                  img_rd_n   = 1'b1;
                  img_addr_n = 6'd0;
               end else begin
                  img_rd_n   = 1'b0;
               end
            end else begin
               state_n = IDLE;
            end
         end
         ISSUE: begin
            if (cmd_r == CMD_LOAD) begin
               img_rd_n   = 1'b1;
               img_addr_n = 6'd1;
               state_n    = LOAD;
            end else begin
               pix_n   = 5'd0;
               to_n    = '0;
               state_n = WAIT_DONE;
            end
         end
         LOAD: begin
            if (img_addr_r == 6'(LOAD_BYTES - 1)) begin
               img_addr_n = 6'd0;
               pix_n      = 5'd0;
               to_n       = '0;
               state_n    = WAIT_DONE;
            end else begin
               img_rd_n   = 1'b1;
               img_addr_n = img_addr_r + 6'd1;
            end
         end
         WAIT_DONE: begin
            pix_inc_s = sat_inc5(pix_cnt_r, output_valid);
            pix_n     = pix_inc_s;
            to_n      = to_cnt_r + TW'(1);
            if (!busy) begin
               cmd_done_n   = 1'b1;
               err_set_s[0] = (pix_inc_s != 5'(PIX_PER_FRAME));
               state_n      = IDLE;
            end else if (to_cnt_r == TW'(TIMEOUT - 1)) begin
               err_set_s[1] = 1'b1;
               state_n      = IDLE;
            end else begin
               state_n = WAIT_DONE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs; a new error beats err_clr in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= IDLE;
         cmd_r       <= 3'd0;
         cmd_valid_r <= 1'b0;
         img_rd_r    <= 1'b0;
         img_addr_r  <= 6'd0;
         cmd_done_r  <= 1'b0;
         err_r       <= 2'b00;
         pix_cnt_r   <= 5'd0;
         to_cnt_r    <= '0;
      end else begin
         state_r     <= state_n;
         cmd_r       <= cmd_n;
         cmd_valid_r <= cmd_valid_n;
         img_rd_r    <= img_rd_n;
         img_addr_r  <= img_addr_n;
         cmd_done_r  <= cmd_done_n;
         err_r       <= (err_r & ~{2{err_clr}}) | err_set_s;
         pix_cnt_r   <= pix_n;
         to_cnt_r    <= to_n;
      end
   end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq with a behavioural LCD controller and image RAM.
`timescale 1ns/1ps
module tb_lcd_cmd_seq;
   import lcd_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] host_cmd = 3'd0;
   logic       host_valid = 1'b0;
   logic       host_ready;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic       busy = 1'b0;
   logic       output_valid = 1'b0;
   logic       img_rd;
   logic [5:0] img_addr;
   logic [7:0] img_data = 8'd0;
   logic       cmd_done;
   logic       seq_busy;
   logic [1:0] err;
   logic       err_clr = 1'b0;

   always #5 clk = ~clk;

   lcd_cmd_seq #(.DEPTH(4), .TIMEOUT(255)) dut (
      .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
      .host_ready(host_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
      .output_valid(output_valid), .img_rd(img_rd), .img_addr(img_addr),
      .img_data(img_data), .cmd_done(cmd_done), .seq_busy(seq_busy),
      .err(err), .err_clr(err_clr)
   );

   // image RAM, one-cycle read latency
   logic [7:0] ram [64];
   always @(posedge clk) if (img_rd) img_data <= ram[img_addr];

   // behavioural LCD controller
   logic [7:0] map [64];
   logic [7:0] burst [16];
   int m_phase = 0, m_k = 0, n_pix = 16, hang_len = 0, cx = 4, cy = 4;
   bit zoom = 1'b0;

   function automatic int pix_idx(input int i);
      int r, c;
      r = i / 4; c = i % 4;
      if (zoom) return (cy - 2 + r) * 8 + (cx - 2 + c);
      else      return (2 * r) * 8 + 2 * c;
   endfunction

   always @(posedge clk) begin
      case (m_phase)
         0: if (cmd_valid) begin
               busy <= 1'b1; m_k <= 0;
               if (hang_len > 0) m_phase <= 3;
               else if (cmd == CMD_LOAD) begin
                  m_phase <= 1; zoom <= 1'b0; cx <= 4; cy <= 4;
               end else begin
                  m_phase <= 2;
                  case (cmd)
                     CMD_ZOOM_IN:  zoom <= 1'b1;
                     CMD_ZOOM_FIT: zoom <= 1'b0;
                     CMD_RIGHT:    if (zoom && cx < 6) cx <= cx + 1;
                     CMD_LEFT:     if (zoom && cx > 2) cx <= cx - 1;
                     CMD_UP:       if (zoom && cy > 2) cy <= cy - 1;
                     CMD_DOWN:     if (zoom && cy < 6) cy <= cy + 1;
                     default: ;
                  endcase
               end
            end
         1: begin
               map[m_k] <= img_data;
               if (m_k == 63) begin m_phase <= 2; m_k <= 0; end
               else m_k <= m_k + 1;
            end
         2: if (m_k < n_pix) begin
               output_valid <= 1'b1; burst[m_k] <= map[pix_idx(m_k)]; m_k <= m_k + 1;
            end else begin
               output_valid <= 1'b0; busy <= 1'b0; m_phase <= 0;
            end
         3: if (m_k >= hang_len - 1) begin busy <= 1'b0; m_phase <= 0; end
            else m_k <= m_k + 1;
         default: m_phase <= 0;
      endcase
   end

   // monitors
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int n_issue = 0, n_done = 0, cv_cycles = 0, busy_viol = 0, issue_cyc = 0;
   logic cv_prev = 1'b0;
   logic [2:0] issued [$];
   logic [5:0] addr_log [$];
   int addr_cyc [$];
   always @(negedge clk) begin
      if (cmd_valid) begin
         cv_cycles++;
         if (busy) busy_viol++;
         if (!cv_prev) begin n_issue++; issue_cyc = cyc; issued.push_back(cmd); end
      end
      cv_prev = cmd_valid;
      if (cmd_done) n_done++;
      if (img_rd) begin addr_log.push_back(img_addr); addr_cyc.push_back(cyc); end
   end

   int n_cmp = 0, n_bad = 0;
   int exp_fit [16] = '{0, 2, 4, 6, 16, 18, 20, 22, 32, 34, 36, 38, 48, 50, 52, 54};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] c, output int waited);
      waited = 0;
      @(negedge clk);
      host_cmd = c; host_valid = 1'b1;
      while (!host_ready && waited < 2000) begin @(negedge clk); waited++; end
      if (waited >= 2000) chk("push_timeout", 32'(host_ready), 32'd1);
      @(posedge clk); #1;
      host_valid = 1'b0;
   endtask

   task automatic wait_quiet();
      int t;
      t = 0;
      @(negedge clk);
      while ((seq_busy || m_phase != 0 || busy) && t < 3000) begin @(negedge clk); t++; end
      chk("quiet_timeout", 32'(t < 3000), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int w, w5, t, bi, bd, ba, bc;
      for (int i = 0; i < 64; i++) ram[i] = 8'(i);
      reset = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_cmd", 32'(cmd), 32'd0);
      chk("rst_img_rd", 32'(img_rd), 32'd0);
      chk("rst_img_addr", 32'(img_addr), 32'd0);
      chk("rst_cmd_done", 32'(cmd_done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_seq_busy", 32'(seq_busy), 32'd0);
      chk("rst_host_ready", 32'(host_ready), 32'd1);
      @(negedge clk); reset = 1'b1;

      // single LOAD
      bi = n_issue; bd = n_done; ba = addr_log.size(); bc = cv_cycles;
      push(CMD_LOAD, w);
      wait_quiet();
      chk("t1_issues", n_issue - bi, 1);
      chk("t1_cv_cycles", cv_cycles - bc, 1);
      chk("t1_cmd", 32'(issued[bi]), 32'(CMD_LOAD));
      chk("t1_addr_count", addr_log.size() - ba, 64);
      chk("t1_addr0_cycle", addr_cyc[ba], issue_cyc);
      for (int k = 0; k < 64; k++) begin
         chk("t1_addr", 32'(addr_log[ba + k]), k);
         chk("t1_addr_cyc", addr_cyc[ba + k] - addr_cyc[ba], k);
         chk("t1_map", 32'(map[k]), k);
      end
      for (int k = 0; k < 16; k++) chk("t1_pix", 32'(burst[k]), exp_fit[k]);
      chk("t1_done", n_done - bd, 1);
      chk("t1_err", 32'(err), 32'd0);

      // back-to-back LOAD, ZOOM_IN, RIGHT, DOWN
      bi = n_issue; bd = n_done; bc = cv_cycles;
      push(CMD_LOAD, w);     chk("t2_ready0", w, 0);
      push(CMD_ZOOM_IN, w);  chk("t2_ready1", w, 0);
      push(CMD_RIGHT, w);    chk("t2_ready2", w, 0);
      push(CMD_DOWN, w);     chk("t2_ready3", w, 0);
      wait_quiet();
      chk("t2_issues", n_issue - bi, 4);
      chk("t2_cv_cycles", cv_cycles - bc, 4);
      chk("t2_order0", 32'(issued[bi]), 32'(CMD_LOAD));
      chk("t2_order1", 32'(issued[bi + 1]), 32'(CMD_ZOOM_IN));
      chk("t2_order2", 32'(issued[bi + 2]), 32'(CMD_RIGHT));
      chk("t2_order3", 32'(issued[bi + 3]), 32'(CMD_DOWN));
      chk("t2_busy_viol", busy_viol, 0);
      chk("t2_first_pix", 32'(burst[0]), 27);
      chk("t2_last_pix", 32'(burst[15]), 54);
      chk("t2_done", n_done - bd, 4);
      chk("t2_err", 32'(err), 32'd0);

      // overfill while LOAD runs
      bi = n_issue; bd = n_done;
      push(CMD_LOAD, w);
      t = 0;
      while (n_issue == bi && t < 100) begin @(negedge clk); t++; end
      chk("t3_load_issued", n_issue - bi, 1);
      push(CMD_ZOOM_IN, w);  chk("t3_q0", w, 0);
      push(CMD_LEFT, w);     chk("t3_q1", w, 0);
      push(CMD_UP, w);       chk("t3_q2", w, 0);
      push(CMD_ZOOM_FIT, w); chk("t3_q3", w, 0);
      chk("t3_full", 32'(host_ready), 32'd0);
      push(CMD_REFLASH, w5);
      chk("t3_held", 32'(w5 > 0), 32'd1);
      wait_quiet();
      chk("t3_issues", n_issue - bi, 6);
      chk("t3_order1", 32'(issued[bi + 1]), 32'(CMD_ZOOM_IN));
      chk("t3_order2", 32'(issued[bi + 2]), 32'(CMD_LEFT));
      chk("t3_order3", 32'(issued[bi + 3]), 32'(CMD_UP));
      chk("t3_order4", 32'(issued[bi + 4]), 32'(CMD_ZOOM_FIT));
      chk("t3_order5", 32'(issued[bi + 5]), 32'(CMD_REFLASH));
      chk("t3_done", n_done - bd, 6);
      chk("t3_busy_viol", busy_viol, 0);

      // controller hangs for 300 cycles
      hang_len = 300; bd = n_done;
      push(CMD_ZOOM_FIT, w);
      t = 0;
      while (!err[1] && t < 1000) begin @(negedge clk); t++; end
      chk("t4_timeout_cycle", cyc - issue_cyc, 256);
      chk("t4_err", 32'(err), 32'd2);
      chk("t4_idle", 32'(seq_busy), 32'd0);
      wait_quiet();
      hang_len = 0;
      chk("t4_no_done", n_done - bd, 0);
      chk("t4_sticky", 32'(err), 32'd2);
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      chk("t4_clear", 32'(err), 32'd0);

      // short burst of 15 pixels
      n_pix = 15; bd = n_done;
      push(CMD_REFLASH, w);
      wait_quiet();
      n_pix = 16;
      chk("t5_done", n_done - bd, 1);
      chk("t5_err", 32'(err), 32'd1);

      // reset during LOAD at address 30, with commands queued
      bi = n_issue;
      push(CMD_LOAD, w);
      push(CMD_ZOOM_IN, w);
      push(CMD_RIGHT, w);
      t = 0;
      while (!(img_rd && img_addr == 6'd30) && t < 200) begin @(negedge clk); t++; end
      chk("t6_reached_30", 32'(img_addr), 32'd30);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("t6_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("t6_cmd", 32'(cmd), 32'd0);
      chk("t6_img_rd", 32'(img_rd), 32'd0);
      chk("t6_img_addr", 32'(img_addr), 32'd0);
      chk("t6_cmd_done", 32'(cmd_done), 32'd0);
      chk("t6_err", 32'(err), 32'd0);
      chk("t6_seq_busy", 32'(seq_busy), 32'd0);
      chk("t6_host_ready", 32'(host_ready), 32'd1);
      @(negedge clk); reset = 1'b1;
      wait_quiet();
      repeat (5) @(negedge clk);
      chk("t6_dropped", n_issue - bi, 1);
      chk("t6_seq_busy_after", 32'(seq_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
